craft_tweakey_scheduler: RTL and testbench
==========================================

# craft_tweakey_scheduler

Parametrised, self-sequencing round-tweakey generator for the CRAFT datapath. A single start latches the 128-bit key, 64-bit tweak and direction. The block then produces all NR round tweakeys with round constants folded in, in encryption (round 0 upward) or decryption (round NR-1 downward) order. Each round tweakey is streamed DW bits per beat over a valid/ready interface to the serial round datapath. It replaces the externally round-driven, fixed 4-bit key register.

## Interface
- DW, 4: output beat width in bits; legal values 4, 8, 16, 32, 64; 64/DW beats per round.
- NR, 32: number of rounds; legal range 2..255.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new schedule; accepted only while busy=0.
- mode  in  1  0 = encryption order, 1 = decryption order; sampled with start.
- abort  in  1  synchronous abandon of the current schedule.
- key  in  128  K0 = key[127:64], K1 = key[63:0]; sampled with start.
- tweak  in  64  T; sampled with start.
- busy  out  1  high from the edge accepting start until return to IDLE.
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  DW  next DW bits of the current round tweakey, MSB-first.
- out_round  out  8  round index of the beat.
- rc  out  8  round constant of out_round, {a[3:0], 1'b0, b[2:0]}.
- out_last_beat  out  1  beat is the final beat of its round.
- out_last_round  out  1  beat belongs to the final round of the schedule.

## Operation
- Cell i of a 64-bit word is bits [63-4i -: 4].
- Q: output cell i = input cell Q[i], with Q = 12,10,15,5,14,8,9,2,11,3,7,4,6,0,1,13.
- Round r tweakey: TK_r = (r even ? K0 : K1) XOR (r mod 4 < 2 ? T : Q(T)).
- Round constant: cell 4 ^= a; cell 5 ^= {0,b}.
- Forward LFSR step: a[2:0]<=a[3:1], a[3]<=a[1]^a[0]; b[1:0]<=b[2:1], b[2]<=b[1]^b[0]. Round 0 uses a=1, b=1.
- Inverse LFSR step: a[3:1]<=a[2:0], a[0]<=a[3]^a[0]; b[2:1]<=b[1:0], b[0]<=b[2]^b[0].
- Decryption starts from the round-(NR-1) constant, computed at elaboration.
- FSM IDLE:
  - On start, latch key, tweak and mode.
  - r <= (mode ? NR-1 : 0); load the matching a/b.
  - Go to LOAD.
- FSM LOAD (one cycle): shift register <= TK_r with rc applied; go to STREAM.
- FSM STREAM:
  - out_data = shift register [63 -: DW].
  - On each beat (out_valid & out_ready), shift left by DW and increment the beat counter.
  - On the last beat of the last round, go to IDLE.
  - On the last beat of any other round, step r by ±1 and the LFSR forward or inverse, then go to LOAD.
- abort: any state goes to IDLE at the next edge; out_valid and busy are 0 after that edge; no further beats.
- start while busy=1 is ignored, including in the cycle abort is sampled.

## Timing
- Reset values: all outputs 0, FSM in IDLE, shift register, r, a/b and beat counter 0.
- start sampled at edge E: busy=1 after E; out_valid=1 after E+1 (first beat available 2 cycles after start).
- Per round: 1 LOAD bubble plus 64/DW beats. Full-rate consumer: a schedule takes NR*(64/DW+1) cycles after start.
- out_valid never drops without a handshake except on abort or reset.
- While out_valid & !out_ready, all out_* and rc are held stable.
- busy falls at the edge completing the final beat; start may be accepted in the following cycle.
- rst_n low mid-schedule clears all state immediately; out_valid falls asynchronously.

## Test plan
- DW=4, NR=32, enc, key=0, tweak=0 -> round 0: cells 4,5 = 1,1 (rc 0x11), all other cells 0; round 1: cells 4,5 = 8,4 (rc 0x84); round 2: rc 0x42; 32 rounds of 16 beats; busy falls after 544 cycles with out_ready=1.
- DW=16, enc, K0=0x0123456789ABCDEF, K1=0, tweak=0 -> round 0 beats 0x0123, 0x5467, 0x89AB, 0xCDEF; out_last_beat set on the 4th beat only.
- DW=64, enc, key=0, tweak=0x0123456789ABCDEF:
  - Round 0 -> 0x0123546789ABCDEF.
  - Round 2 -> 0xCAF5AA92B374601D (Q applied, rc 0x42).
  - Round 3 -> Q(T) with rc 0x25.
- DW=4, NR=32, dec, key=0, tweak=0 -> first out_round=31 with cells 4,5 = 8,5 (rc 0x85); next round 30 with rc 0x12; last round 0 with rc 0x11 and out_last_round=1.
- Random out_ready stalls -> beat sequence identical to the no-stall run; outputs stable during stalls.
- abort mid-round 5 -> out_valid=0 and busy=0 next cycle; start pulsed while busy -> ignored.
- rst_n low mid-stream -> outputs 0 immediately; a later start gives a clean round-0 stream.

Source files
------------

// File: rtl/craft_tweakey_scheduler.sv
// CRAFT round-tweakey generator: latches key/tweak/direction on start, then streams every
// round tweakey (round constant folded in) DW bits per beat over a valid/ready interface.
module craft_tweakey_scheduler #(
  parameter int unsigned DW = 4,
  parameter int unsigned NR = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic          abort,
  input  logic [127:0]  key,
  input  logic [63:0]   tweak,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [7:0]    out_round,
  output logic [7:0]    rc,
  output logic          out_last_beat,
  output logic          out_last_round
);

  localparam int unsigned Beats = 64 / DW;
  // Q permutation: output cell i takes input cell QTab cell i.
  localparam logic [63:0] QTab = 64'hCAF5E892B374601D;

  // {a, b} of round NR-1, the starting point of a decryption schedule.
  function automatic logic [6:0] last_ab();
    logic [3:0] a;
    logic [2:0] b;
    a = 4'd1;
    b = 3'd1;
    for (int unsigned i = 1; i < NR; i++) begin
      a = {a[1] ^ a[0], a[3:1]};
      b = {b[1] ^ b[0], b[2:1]};
    end
    return {a, b};
  endfunction

  localparam logic [6:0] LastAb = last_ab();

  function automatic logic [63:0] perm_q(input logic [63:0] x);
    logic [63:0] y;
    logic [3:0]  src;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      src = QTab[63-4*i -: 4];
      y[63-4*i -: 4] = x[63-4*int'(src) -: 4];
    end
    return y;
  endfunction

  typedef enum logic [1:0] {StIdle, StLoad, StStream} state_e;

  state_e         state_q, state_d;
  logic [127:0]   key_q;
  logic [63:0]    tweak_q;
  logic           mode_q;
  logic [7:0]     r_q;
  logic [3:0]     a_q;
  logic [2:0]     b_q;
  logic [4:0]     beat_q;
  logic [63:0]    shreg_q;
  logic [63:0]    tk;
  logic           fire;
  logic           last_beat;
  logic           last_round;

  assign fire       = (state_q == StStream) && out_ready;
  assign last_beat  = beat_q == 5'(Beats - 1);
  assign last_round = r_q == (mode_q ? 8'd0 : 8'(NR - 1));

  // Even rounds use K0, odd K1; rounds with r mod 4 >= 2 use the permuted tweak.
  always_comb begin
    tk = (r_q[0] ? key_q[63:0] : key_q[127:64]) ^ (r_q[1] ? perm_q(tweak_q) : tweak_q);
    tk[47:40] = tk[47:40] ^ {a_q, 1'b0, b_q};
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:   if (start) state_d = StLoad;
        StLoad:   state_d = StStream;
        StStream: if (fire && last_beat) state_d = last_round ? StIdle : StLoad;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      key_q   <= '0;
      tweak_q <= '0;
      mode_q  <= 1'b0;
      r_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      beat_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      if (!abort) begin
        case (state_q)
          StIdle: begin
            if (start) begin
              key_q      <= key;
              tweak_q    <= tweak;
              mode_q     <= mode;
              r_q        <= mode ? 8'(NR - 1) : 8'd0;
              {a_q, b_q} <= mode ? LastAb : 7'b0001_001;
            end
          end
          StLoad: begin
            shreg_q <= tk;
            beat_q  <= '0;
          end
          StStream: begin
            if (fire) begin
              shreg_q <= shreg_q << DW;
              beat_q  <= beat_q + 5'd1;
              if (last_beat && !last_round) begin
                if (mode_q) begin
                  r_q <= r_q - 8'd1;
                  a_q <= {a_q[2:0], a_q[3] ^ a_q[0]};
                  b_q <= {b_q[1:0], b_q[2] ^ b_q[0]};
                end else begin
                  r_q <= r_q + 8'd1;
                  a_q <= {a_q[1] ^ a_q[0], a_q[3:1]};
                  b_q <= {b_q[1] ^ b_q[0], b_q[2:1]};
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy           = state_q != StIdle;
  assign out_valid      = state_q == StStream;
  assign out_data       = shreg_q[63 -: DW];
  assign out_round      = r_q;
  assign rc             = {a_q, 1'b0, b_q};
  assign out_last_beat  = out_valid && last_beat;
  assign out_last_round = out_valid && last_round;

endmodule

// File: tb/tb_craft_tweakey_scheduler.sv
// Self-checking bench for craft_tweakey_scheduler: randomized stimulus against a
// word-level reference model of the round tweakey schedule.
module tb_craft_tweakey_scheduler;

  localparam int DW    = 4;
  localparam int NR    = 32;
  localparam int BEATS = 64 / DW;
  localparam int TOTAL = NR * BEATS;
  localparam int QPERM [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          abort = 1'b0;
  logic [127:0]  key = '0;
  logic [63:0]   tweak = '0;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [7:0]    out_round;
  logic [7:0]    rc;
  logic          out_last_beat;
  logic          out_last_round;

  craft_tweakey_scheduler #(.DW(DW), .NR(NR)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort), .key(key),
    .tweak(tweak), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_round(out_round), .rc(rc), .out_last_beat(out_last_beat),
    .out_last_round(out_last_round)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] word_seen [256];
  logic [7:0]  rc_seen [256];

  // Round constant of round r: run both LFSRs forward r times from a=1, b=1.
  function automatic logic [7:0] model_rc(input int r);
    int a = 1;
    int b = 1;
    for (int i = 0; i < r; i++) begin
      a = (a >> 1) | ((((a >> 1) ^ a) & 1) << 3);
      b = (b >> 1) | ((((b >> 1) ^ b) & 1) << 2);
    end
    return 8'((a << 4) | b);
  endfunction

  function automatic logic [63:0] model_tk(input logic [127:0] k, input logic [63:0] t,
                                           input int r);
    logic [63:0] tw;
    logic [63:0] w;
    logic [7:0]  c;
    tw = t;
    if (r % 4 >= 2)
      for (int i = 0; i < 16; i++) tw[63-4*i -: 4] = t[63-4*QPERM[i] -: 4];
    w = ((r % 2 == 0) ? k[127:64] : k[63:0]) ^ tw;
    c = model_rc(r);
    w[47:44] = w[47:44] ^ c[7:4];
    w[43:40] = w[43:40] ^ c[3:0];
    return w;
  endfunction

  // Starts a schedule at the current negedge and follows it until busy falls.
  task automatic run_sched(input bit md, input logic [127:0] k, input logic [63:0] t,
                           input int stall_pct, input bit pulse, output int beats,
                           output int bad, output int holdbad, output int done_cyc,
                           output int first_valid, output int first_round,
                           output logic busy0);
    logic [DW+18:0] cur;
    logic [DW+18:0] hold_val;
    logic           held;
    logic           rdy;
    logic           completing;
    logic [63:0]    w;
    int             cyc, p, j, r;
    for (int i = 0; i < 256; i++) begin
      word_seen[i] = '0;
      rc_seen[i]   = '0;
    end
    beats = 0; bad = 0; holdbad = 0; done_cyc = -1; first_valid = -1; first_round = -1;
    held = 1'b0; hold_val = '0;
    start = 1'b1; mode = md; key = k; tweak = t;
    @(negedge clk);
    start = 1'b0;
    busy0 = busy;
    cyc = 0;
    while (cyc < 20000) begin
      if (!busy) begin
        done_cyc = cyc;
        break;
      end
      cur = {out_valid, out_data, out_round, rc, out_last_beat, out_last_round};
      if (held && cur !== hold_val) holdbad++;
      held = 1'b0;
      rdy = ($urandom_range(99) >= stall_pct);
      completing = 1'b0;
      if (out_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          first_round = int'(out_round);
        end
        if (beats < TOTAL) begin
          p = beats / BEATS;
          j = beats % BEATS;
          r = md ? NR - 1 - p : p;
          w = model_tk(k, t, r);
          if ({out_data, out_round, rc, out_last_beat, out_last_round} !==
              {w[63-DW*j -: DW], 8'(r), model_rc(r), j == BEATS - 1, p == NR - 1}) bad++;
          completing = rdy && (beats == TOTAL - 1);
        end else begin
          bad++;
        end
        if (rdy) begin
          word_seen[out_round] = {word_seen[out_round][63-DW:0], out_data};
          rc_seen[out_round]   = rc;
          beats++;
        end else begin
          held = 1'b1;
          hold_val = cur;
        end
      end
      out_ready = rdy;
      start = pulse && !completing && ($urandom_range(3) == 0);
      if (start) begin
        key   = {$urandom, $urandom, $urandom, $urandom};
        tweak = {$urandom, $urandom};
        mode  = 1'($urandom_range(1));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  int   g_beats, g_bad, g_hold, g_done, g_fv, g_fr;
  logic g_busy0;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, out_valid, out_data, out_round, rc, out_last_beat, out_last_round} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {busy, out_valid, out_data, out_round, rc, out_last_beat, out_last_round});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_enc_zero();
    run_sched(1'b0, '0, '0, 0, 1'b0, g_beats, g_bad, g_hold, g_done, g_fv, g_fr, g_busy0);
    n_cmp++; if (g_busy0 !== 1'b1) begin n_err++; $display("FAIL enc_busy_rise: got %b want 1", g_busy0); end
    n_cmp++; if (g_fv != 1) begin n_err++; $display("FAIL enc_first_valid: got %0d want 1", g_fv); end
    n_cmp++; if (g_beats != TOTAL) begin n_err++; $display("FAIL enc_beats: got %0d want %0d", g_beats, TOTAL); end
    n_cmp++; if (g_bad != 0) begin n_err++; $display("FAIL enc_stream: bad beats %0d want 0", g_bad); end
    n_cmp++; if (g_done != 544) begin n_err++; $display("FAIL enc_cycles: got %0d want 544", g_done); end
    n_cmp++; if (word_seen[0] !== 64'h0000_1100_0000_0000) begin n_err++; $display("FAIL enc_round0: got %h want 0000110000000000", word_seen[0]); end
    n_cmp++; if (rc_seen[1] !== 8'h84) begin n_err++; $display("FAIL enc_rc1: got %h want 84", rc_seen[1]); end
    n_cmp++; if (rc_seen[2] !== 8'h42) begin n_err++; $display("FAIL enc_rc2: got %h want 42", rc_seen[2]); end
  endtask

  task automatic test_k0_pattern();
    run_sched(1'b0, {64'h0123_4567_89AB_CDEF, 64'h0}, '0, 0, 1'b0,
              g_beats, g_bad, g_hold, g_done, g_fv, g_fr, g_busy0);
    n_cmp++; if (word_seen[0] !== 64'h0123_5467_89AB_CDEF) begin n_err++; $display("FAIL k0_round0: got %h want 0123546789abcdef", word_seen[0]); end
    n_cmp++; if (word_seen[1] !== 64'h0000_8400_0000_0000) begin n_err++; $display("FAIL k0_round1: got %h want 0000840000000000", word_seen[1]); end
    n_cmp++; if (g_bad != 0) begin n_err++; $display("FAIL k0_stream: bad beats %0d want 0", g_bad); end
  endtask

  task automatic test_tweak_pattern();
    run_sched(1'b0, '0, 64'h0123_4567_89AB_CDEF, 0, 1'b0,
              g_beats, g_bad, g_hold, g_done, g_fv, g_fr, g_busy0);
    n_cmp++; if (word_seen[0] !== 64'h0123_5467_89AB_CDEF) begin n_err++; $display("FAIL tw_round0: got %h want 0123546789abcdef", word_seen[0]); end
    n_cmp++; if (word_seen[2] !== 64'hCAF5_AA92_B374_601D) begin n_err++; $display("FAIL tw_round2: got %h want caf5aa92b374601d", word_seen[2]); end
    n_cmp++; if (word_seen[3] !== 64'hCAF5_CD92_B374_601D) begin n_err++; $display("FAIL tw_round3: got %h want caf5cd92b374601d", word_seen[3]); end
    n_cmp++; if (rc_seen[3] !== 8'h25) begin n_err++; $display("FAIL tw_rc3: got %h want 25", rc_seen[3]); end
    n_cmp++; if (g_bad != 0) begin n_err++; $display("FAIL tw_stream: bad beats %0d want 0", g_bad); end
  endtask

  task automatic test_dec_zero();
    run_sched(1'b1, '0, '0, 0, 1'b0, g_beats, g_bad, g_hold, g_done, g_fv, g_fr, g_busy0);
    n_cmp++; if (g_fr != NR - 1) begin n_err++; $display("FAIL dec_first_round: got %0d want %0d", g_fr, NR - 1); end
    n_cmp++; if (rc_seen[31] !== 8'h85) begin n_err++; $display("FAIL dec_rc31: got %h want 85", rc_seen[31]); end
    n_cmp++; if (rc_seen[30] !== 8'h12) begin n_err++; $display("FAIL dec_rc30: got %h want 12", rc_seen[30]); end
    n_cmp++; if (rc_seen[0] !== 8'h11) begin n_err++; $display("FAIL dec_rc0: got %h want 11", rc_seen[0]); end
    n_cmp++; if (g_bad != 0) begin n_err++; $display("FAIL dec_stream: bad beats %0d want 0", g_bad); end
    n_cmp++; if (g_done != 544) begin n_err++; $display("FAIL dec_cycles: got %0d want 544", g_done); end
  endtask

  task automatic test_random_stalls();
    for (int n = 0; n < 3; n++) begin
      run_sched(1'($urandom_range(1)), {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom}, 40, 1'b1, g_beats, g_bad, g_hold, g_done, g_fv, g_fr,
                g_busy0);
      n_cmp++; if (g_done <= 0) begin n_err++; $display("FAIL stall_done: got %0d want >0", g_done); end
      n_cmp++; if (g_beats != TOTAL) begin n_err++; $display("FAIL stall_beats: got %0d want %0d", g_beats, TOTAL); end
      n_cmp++; if (g_bad != 0) begin n_err++; $display("FAIL stall_stream: bad beats %0d want 0", g_bad); end
      n_cmp++; if (g_hold != 0) begin n_err++; $display("FAIL stall_hold: unstable %0d want 0", g_hold); end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 2; n++) begin
      run_sched(1'(n), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 0,
                1'b0, g_beats, g_bad, g_hold, g_done, g_fv, g_fr, g_busy0);
      n_cmp++; if (g_busy0 !== 1'b1) begin n_err++; $display("FAIL b2b_accept: busy got %b want 1", g_busy0); end
      n_cmp++; if (g_bad != 0 || g_beats != TOTAL) begin n_err++; $display("FAIL b2b_stream: bad %0d beats %0d want 0/%0d", g_bad, g_beats, TOTAL); end
    end
  endtask

  task automatic test_abort();
    int cnt;
    int stray;
    start = 1'b1; mode = 1'b0; key = {$urandom, $urandom, $urandom, $urandom}; tweak = '0;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    cnt = 0;
    while (!(out_valid && out_round == 8'd5) && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++; if (cnt >= 400) begin n_err++; $display("FAIL abort_reach_round5: got timeout want round 5"); end
    repeat (7) @(negedge clk);
    abort = 1'b1; start = 1'b1; mode = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    n_cmp++; if ({busy, out_valid} !== 2'b00) begin n_err++; $display("FAIL abort_stop: busy/valid got %b want 00", {busy, out_valid}); end
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || out_valid) stray++;
    end
    n_cmp++; if (stray != 0) begin n_err++; $display("FAIL abort_quiet: active cycles %0d want 0", stray); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k;
    logic [63:0]  t;
    start = 1'b1; mode = 1'b0; key = {$urandom, $urandom, $urandom, $urandom};
    tweak = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, out_valid, out_data, out_round, rc, out_last_beat, out_last_round} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %h want 0",
               {busy, out_valid, out_data, out_round, rc, out_last_beat, out_last_round});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    k = {$urandom, $urandom, $urandom, $urandom};
    t = {$urandom, $urandom};
    run_sched(1'b0, k, t, 0, 1'b0, g_beats, g_bad, g_hold, g_done, g_fv, g_fr, g_busy0);
    n_cmp++; if (g_fr != 0) begin n_err++; $display("FAIL rst_mid_round0: got %0d want 0", g_fr); end
    n_cmp++; if (g_bad != 0 || g_beats != TOTAL) begin n_err++; $display("FAIL rst_mid_stream: bad %0d beats %0d want 0/%0d", g_bad, g_beats, TOTAL); end
    n_cmp++; if (word_seen[0] !== model_tk(k, t, 0)) begin n_err++; $display("FAIL rst_mid_word0: got %h want %h", word_seen[0], model_tk(k, t, 0)); end
  endtask

  initial begin
    test_reset();
    test_enc_zero();
    test_k0_pattern();
    test_tweak_pattern();
    test_dec_zero();
    test_random_stalls();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
